rans_decoder: RTL and testbench

RANS_DECODER -- requirements
Module: rans_decoder

---
 rtl/rans_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_rans_decoder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rans_decoder.sv
// rANS decoder: slot-table fill engine plus a LOOKUP/UPDATE/EMIT/RENORM decode loop.
// Define RANS_DEC_ERR_EN to add err_o and per-slot written tracking.
module rans_decoder #(
    parameter int RESOLUTION   = 10,
    parameter int SYMBOL_WIDTH = 8,
    parameter int LEN_WIDTH    = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               freq_wr_i,
    input  logic [SYMBOL_WIDTH-1:0]            symb_i,
    input  logic [RESOLUTION-1:0]              freq_i,
    input  logic [RESOLUTION-1:0]              cum_freq_i,
    output logic                               busy_o,
    input  logic                               start_i,
    input  logic [RESOLUTION+SYMBOL_WIDTH-1:0] state_i,
    input  logic [LEN_WIDTH-1:0]               len_i,
    input  logic                               enc_valid_i,
    output logic                               enc_ready_o,
    input  logic [SYMBOL_WIDTH-1:0]            enc_i,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [SYMBOL_WIDTH-1:0]            symb_o,
`ifdef RANS_DEC_ERR_EN
    output logic                               err_o,
`endif
    output logic                               done_o
);
    localparam int M    = 1 << RESOLUTION;
    localparam int XW   = RESOLUTION + SYMBOL_WIDTH;
    localparam int NSYM = 1 << SYMBOL_WIDTH;

    typedef enum logic [2:0] {IDLE, LOOKUP, UPDATE, EMIT, RENORM} state_t;
    state_t state, next_state;

    logic [SYMBOL_WIDTH-1:0] slot_tab [M];
    logic [RESOLUTION-1:0]   freq_tab [NSYM];
    logic [RESOLUTION-1:0]   cum_tab  [NSYM];

    logic                    busy;
    logic [SYMBOL_WIDTH-1:0] fill_sym;
    logic [RESOLUTION-1:0]   fill_idx;
    logic [RESOLUTION-1:0]   fill_cnt;

    logic [XW-1:0]           x;
    logic [LEN_WIDTH-1:0]    count;
    logic [SYMBOL_WIDTH-1:0] lookup_sym;
    logic [SYMBOL_WIDTH-1:0] symb_q;
    logic                    done_q;
    logic                    table_wr;
    logic                    x_low;
    logic [RESOLUTION-1:0]   upd_f;
    logic [RESOLUTION-1:0]   upd_c;
    logic [XW:0]             upd_x;

`ifdef RANS_DEC_ERR_EN
    logic [M-1:0]            written;
    logic                    err_q;
    assign err_o = err_q;
`endif

    assign table_wr    = freq_wr_i && !busy && (state == IDLE);
    assign x_low       = (x[XW-1:RESOLUTION] == '0);
    assign upd_f       = freq_tab[lookup_sym];
    assign upd_c       = cum_tab[lookup_sym];
    assign busy_o      = busy;
    assign symb_o      = symb_q;
    assign done_o      = done_q;

    // Full-precision state transition; the top bit is dropped when stored.
    assign upd_x = (XW+1)'(upd_f) * (XW+1)'(x[XW-1:RESOLUTION])
                 + (XW+1)'(x[RESOLUTION-1:0]) - (XW+1)'(upd_c);

    // Table storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk_i) begin
        if (rst_i && table_wr) begin
            freq_tab[symb_i] <= freq_i;
            cum_tab[symb_i]  <= cum_freq_i;
        end
        if (rst_i && busy) begin
            slot_tab[fill_idx] <= fill_sym;
        end
        if (state == LOOKUP) begin
            lookup_sym <= slot_tab[x[RESOLUTION-1:0]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            busy     <= 1'b0;
            fill_sym <= '0;
            fill_idx <= '0;
            fill_cnt <= '0;
            x        <= '0;
            count    <= '0;
            symb_q   <= '0;
            done_q   <= 1'b0;
`ifdef RANS_DEC_ERR_EN
            written  <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state  <= next_state;
            done_q <= 1'b0;

            if (busy) begin
                fill_idx <= fill_idx + RESOLUTION'(1);
                fill_cnt <= fill_cnt - RESOLUTION'(1);
`ifdef RANS_DEC_ERR_EN
                written[fill_idx] <= 1'b1;
`endif
                if (fill_cnt == RESOLUTION'(1)) begin
                    busy <= 1'b0;
                end
            end else if (table_wr) begin
                busy     <= (freq_i != '0);
                fill_sym <= symb_i;
                fill_idx <= cum_freq_i;
                fill_cnt <= freq_i;
            end

            case (state)
                IDLE: begin
                    if (start_i && !busy) begin
                        if (len_i != '0) begin
                            x     <= state_i;
                            count <= len_i;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
`ifdef RANS_DEC_ERR_EN
                    if (start_i) begin
                        err_q <= 1'b0;
                    end
`endif
                end
                LOOKUP: begin
`ifdef RANS_DEC_ERR_EN
                    if (!written[x[RESOLUTION-1:0]]) begin
                        err_q <= 1'b1;
                    end
`endif
                end
                UPDATE: begin
                    x      <= upd_x[XW-1:0];
                    symb_q <= lookup_sym;
                end
                EMIT: begin
                    if (ready_i) begin
                        count <= count - LEN_WIDTH'(1);
                    end
                end
                RENORM: begin
                    if (x_low && enc_valid_i) begin
                        x <= {x[RESOLUTION-1:0], enc_i};
                    end else if (!x_low && count == '0) begin
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state  = state;
        valid_o     = 1'b0;
        enc_ready_o = 1'b0;
        case (state)
            IDLE: begin
                if (start_i && !busy && len_i != '0) begin
                    next_state = LOOKUP;
                end
            end
            LOOKUP: begin
                next_state = UPDATE;
`ifdef RANS_DEC_ERR_EN
                if (!written[x[RESOLUTION-1:0]]) begin
                    next_state = IDLE;
                end
`endif
            end
            UPDATE: next_state = EMIT;
            EMIT: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    next_state = RENORM;
                end
            end
            RENORM: begin
                enc_ready_o = x_low;
                if (!x_low) begin
                    next_state = (count == '0) ? IDLE : LOOKUP;
                end
            end
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rans_decoder.sv
// Self-checking bench for rans_decoder: directed table/decode cases plus a
// randomized encode/decode round trip against an arithmetic rANS model.
module tb_rans_decoder;
    localparam int RES = 10;
    localparam int SW  = 8;
    localparam int LW  = 16;
    localparam int M   = 1 << RES;
    localparam int NMSG = 1000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            freq_wr = 1'b0;
    logic [SW-1:0]   wr_symb = '0;
    logic [RES-1:0]  wr_freq = '0;
    logic [RES-1:0]  wr_cum = '0;
    logic            busy;
    logic            start = 1'b0;
    logic [RES+SW-1:0] start_state = '0;
    logic [LW-1:0]   start_len = '0;
    logic            enc_valid = 1'b0;
    logic            enc_ready;
    logic [SW-1:0]   enc_byte = '0;
    logic            valid;
    logic            ready = 1'b0;
    logic [SW-1:0]   symb;
    logic            done;
`ifdef RANS_DEC_ERR_EN
    logic            err;
`endif

    int check_cnt = 0;
    int pass_cnt  = 0;
    int done_cnt  = 0;
    int valid_cnt = 0;
    int ready_mode = 0;
    int enc_mode   = 0;
    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] enc_q[$];
    logic [SW-1:0] ref_slot [M];
    int ref_f [256];
    int ref_c [256];
    logic prev_stall = 1'b0;
    logic [SW-1:0] prev_symb = '0;

    rans_decoder #(.RESOLUTION(RES), .SYMBOL_WIDTH(SW), .LEN_WIDTH(LW)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .freq_wr_i(freq_wr), .symb_i(wr_symb), .freq_i(wr_freq), .cum_freq_i(wr_cum),
        .busy_o(busy),
        .start_i(start), .state_i(start_state), .len_i(start_len),
        .enc_valid_i(enc_valid), .enc_ready_o(enc_ready), .enc_i(enc_byte),
        .valid_o(valid), .ready_i(ready), .symb_o(symb),
`ifdef RANS_DEC_ERR_EN
        .err_o(err),
`endif
        .done_o(done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        check_cnt++;
        if (actual == expected) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Consumer/producer handshake driver, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: ready = 1'b0;
                1: ready = 1'b1;
                default: ready = ($urandom_range(0, 3) != 0);
            endcase
            if (enc_q.size() > 0 && (enc_mode == 1 || (enc_mode == 2 && $urandom_range(0, 2) != 0))) begin
                enc_valid = 1'b1;
                enc_byte  = enc_q[0];
            end else begin
                enc_valid = 1'b0;
                enc_byte  = 8'($urandom);
            end
        end
    end

    // Compare process: every accepted symbol against the model queue, stalls must hold.
    always @(negedge clk) begin
        if (prev_stall) begin
            checkOutput("hold_valid", valid, 1);
            checkOutput("hold_symb", symb, prev_symb);
        end
        if (done) done_cnt++;
        if (valid) valid_cnt++;
        if (rst_n && valid && ready) begin
            if (exp_q.size() == 0) begin
                check_cnt++;
                $display("[TB] FAIL unexpected_symbol: got 0x%0h, expected none", symb);
            end else begin
                checkOutput("symb", symb, exp_q.pop_front());
            end
        end
        if (rst_n && enc_valid && enc_ready && enc_q.size() > 0) void'(enc_q.pop_front());
        prev_stall = rst_n && valid && !ready;
        prev_symb  = symb;
    end

    function automatic int modelStep(input int x, output int s);
        s = int'(ref_slot[x % M]);
        return ref_f[s] * (x >> RES) + (x % M) - ref_c[s];
    endfunction

    task automatic writeFreq(input int s, input int f, input int c, input bit spur);
        int cnt = 0;
        @(posedge clk); #1;
        freq_wr = 1'b1; wr_symb = 8'(s); wr_freq = 10'(f); wr_cum = 10'(c);
        @(posedge clk); #1;
        freq_wr = 1'b0;
        for (int k = 0; k < f; k++) ref_slot[(c + k) % M] = 8'(s);
        ref_f[s] = f;
        ref_c[s] = c;
        for (int t = 0; t < f + 20; t++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            if (spur && cnt == 3) begin
                freq_wr = 1'b1; wr_symb = 8'h43; wr_freq = 10'd5; wr_cum = 10'd0;
            end else begin
                freq_wr = 1'b0;
            end
        end
        freq_wr = 1'b0;
        checkOutput($sformatf("busy_cycles_%0h", s), cnt, f);
    endtask

    task automatic applyStimulus(input logic [RES+SW-1:0] st, input int len);
        @(posedge clk); #1;
        start = 1'b1; start_state = st; start_len = 16'(len);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string name);
        bit seen = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        checkOutput(name, seen, 1);
    endtask

    task automatic waitValid(input int budget, output int lat);
        lat = budget + 1;
        for (int t = 1; t <= budget; t++) begin
            @(negedge clk);
            if (valid) begin lat = t; break; end
        end
    endtask

    initial begin
        int s, x, lat, base, vb, nsym, remaining, cum, f, errs;
        bit seen;
        bit used [256];
        int syms [8];
        int msg [NMSG];
        logic [SW-1:0] emitted[$];
        logic [SW-1:0] model_bytes[$];

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_valid", valid, 0);
        checkOutput("rst_enc_ready", enc_ready, 0);
        checkOutput("rst_done", done, 0);

        writeFreq('h41, 512, 0, 1'b1);
`ifdef RANS_DEC_ERR_EN
        vb = valid_cnt;
        applyStimulus(18'h00600, 1);
        repeat (6) @(negedge clk);
        checkOutput("err_set", err, 1);
        checkOutput("err_no_valid", valid_cnt - vb, 0);
`endif
        writeFreq('h42, 512, 512, 1'b0);

        // Hand-computed pins: 0x600 -> slot 0x200 -> 0x42, x = 512*1+512-512 = 0x200.
        x = modelStep(32'h600, s);
        checkOutput("model_sym", s, 'h42);
        checkOutput("model_x", x, 'h200);
        checkOutput("model_x_renorm", (x << SW) | 'hAB, 'h200AB);

        exp_q.push_back(8'(s));
        enc_q.push_back(8'hAB);
        ready_mode = 1; enc_mode = 1;
        base = done_cnt;
        applyStimulus(18'h00600, 1);
        waitDone(50, "single_done");
        repeat (3) @(negedge clk);
        checkOutput("single_exp_left", exp_q.size(), 0);
        checkOutput("single_bytes_left", enc_q.size(), 0);
        checkOutput("single_done_count", done_cnt - base, 1);

        exp_q.push_back(8'h42);
        enc_q.push_back(8'hAB);
        ready_mode = 0;
        applyStimulus(18'h00600, 1);
        waitValid(20, lat);
        checkOutput("latency", lat, 3);
        repeat (10) @(negedge clk);
        checkOutput("stall_bytes_left", enc_q.size(), 1);
        checkOutput("stall_enc_ready", enc_ready, 0);
        ready_mode = 1;
        waitDone(50, "stall_done");
        repeat (2) @(negedge clk);
        checkOutput("stall_bytes_used", enc_q.size(), 0);

        vb = valid_cnt;
        applyStimulus(18'h00600, 0);
        @(negedge clk);
        checkOutput("len0_done", done, 1);
        @(negedge clk);
        checkOutput("len0_done_pulse", done, 0);
        checkOutput("len0_no_valid", valid_cnt - vb, 0);

        exp_q.push_back(8'h42);
        enc_q.delete();
        enc_mode = 0;
        applyStimulus(18'h00600, 1);
        seen = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (enc_ready) begin seen = 1'b1; break; end
        end
        checkOutput("renorm_reached", seen, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midrst_valid", valid, 0);
        checkOutput("midrst_enc_ready", enc_ready, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_symb", symb, 0);
        exp_q.push_back(8'h42);
        enc_q.push_back(8'hAB);
        enc_mode = 1;
        applyStimulus(18'h00600, 1);
        waitDone(50, "postrst_done");
        repeat (2) @(negedge clk);
        checkOutput("postrst_exp_left", exp_q.size(), 0);
        checkOutput("postrst_bytes_left", enc_q.size(), 0);

        // Random table covering all M slots.
        for (int i = 0; i < 256; i++) used[i] = 1'b0;
        nsym = $urandom_range(3, 8);
        remaining = M;
        cum = 0;
        for (int i = 0; i < nsym; i++) begin
            do s = $urandom_range(0, 255); while (used[s]);
            used[s] = 1'b1;
            syms[i] = s;
            if (i == nsym - 1) f = remaining;
            else f = $urandom_range(1, (remaining - (nsym - 1 - i)) / 2 + 1);
            writeFreq(s, f, cum, 1'b0);
            cum += f;
            remaining -= f;
        end

        // Reference encoder: x starts at M, bytes emitted LSB first before each step.
        x = M;
        for (int i = 0; i < NMSG; i++) begin
            msg[i] = syms[$urandom_range(0, nsym - 1)];
            s = msg[i];
            while (x >= (ref_f[s] << SW)) begin
                emitted.push_back(8'(x & 255));
                x = x >> SW;
            end
            x = ((x / ref_f[s]) << RES) + (x % ref_f[s]) + ref_c[s];
        end

        for (int i = emitted.size() - 1; i >= 0; i--) begin
            enc_q.push_back(emitted[i]);
            model_bytes.push_back(emitted[i]);
        end
        for (int i = NMSG - 1; i >= 0; i--) exp_q.push_back(8'(msg[i]));

        begin
            int xm, sm;
            xm = x;
            errs = 0;
            for (int i = NMSG - 1; i >= 0; i--) begin
                xm = modelStep(xm, sm);
                if (sm != msg[i]) errs++;
                while (xm < M && model_bytes.size() > 0) xm = (xm << SW) | int'(model_bytes.pop_front());
            end
            checkOutput("model_roundtrip_errs", errs, 0);
            checkOutput("model_final_x", xm, M);
        end

        ready_mode = 2; enc_mode = 2;
        base = done_cnt;
        applyStimulus(18'(x), NMSG);
        waitDone(40000, "rt_done");
        repeat (5) @(negedge clk);
        checkOutput("rt_exp_left", exp_q.size(), 0);
        checkOutput("rt_bytes_left", enc_q.size(), 0);
        checkOutput("rt_done_count", done_cnt - base, 1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
